// File: rtl/dual_core_ctx_cpu.sv
// dual_core_ctx_cpu: two single-cycle RISC cores on one loadable imem; in sclk/reset/load/addr/instr, out pc0_o/pc1_o/c1_run_o/c1_bank_o
module dual_core_ctx_cpu #(
  parameter int IMEM_WORDS = 256
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] addr,
  input  logic [31:0] instr,
  output logic [31:0] pc0_o,
  output logic [31:0] pc1_o,
  output logic        c1_run_o,
  output logic        c1_bank_o
);
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] r0 [32];
  logic [31:0] r1 [2][32];
  logic [31:0] pc0, pc1, bar, i0, i1, a0, b0, a1, b1, pc0_n, pc1_n, res0, res1;
  logic [15:0] sc0, sc1, sc0_n, sc1_n;
  logic [4:0] w0, w1;
  logic c1_run, c1_bank, go0, go1, slp0, slp1, lba, bcpu, bcpujr, ctl;
  logic unused;
  function automatic logic [4:0] dst(input logic [31:0] i);
    return i[31:26] == 6'h28 ? i[20:16] :
           i[31:26] == 6'h00 && (i[5:0] == 6'h08 || i[5:0] == 6'h0A || i[5:0] == 6'h0C || i[5:0] == 6'h0D) ? i[15:11] : 5'd0;
  endfunction
  function automatic logic [31:0] res(input logic [31:0] i, a, b);
    return i[31:26] == 6'h28 ? a + {{16{i[15]}}, i[15:0]} : i[5:0] == 6'h08 ? a + b :
           i[5:0] == 6'h0A ? a - b : i[5:0] == 6'h0C ? a & b : a | b;
  endfunction
  function automatic logic [31:0] npc(input logic [31:0] i, pc);
    return i[31:26] == 6'h05 ? {pc[31:28], i[25:0], 2'b00} : pc + 32'd4;
  endfunction
  assign unused = ^{addr[31:10], addr[1:0]};
  assign i0 = imem[pc0[9:2]];
  assign i1 = imem[pc1[9:2]];
  assign a0 = r0[i0[25:21]];
  assign b0 = r0[i0[20:16]];
  assign a1 = r1[c1_bank][i1[25:21]];
  assign b1 = r1[c1_bank][i1[20:16]];
  assign pc0_o = pc0;
  assign pc1_o = pc1;
  assign c1_run_o = c1_run;
  assign c1_bank_o = c1_bank;
  always_comb begin
    go0 = sc0 == 16'd0;
    slp0 = go0 && i0[31:26] == 6'h08 && i0[15:0] != 16'd0;
    lba = go0 && i0[31:26] == 6'h0D;
    bcpu = go0 && i0[31:26] == 6'h0C && i0[25:21] == 5'd1;
    bcpujr = go0 && i0[31:26] == 6'h0F;
    ctl = bcpu || bcpujr;
    pc0_n = !go0 ? (sc0 == 16'd1 ? pc0 + 32'd4 : pc0) : slp0 ? pc0 : npc(i0, pc0);
    sc0_n = !go0 ? sc0 - 16'd1 : slp0 ? i0[15:0] : 16'd0;
    w0 = go0 ? dst(i0) : 5'd0;
    res0 = res(i0, a0, b0);
    go1 = c1_run && sc1 == 16'd0 && !ctl;
    slp1 = i1[31:26] == 6'h08 && i1[15:0] != 16'd0;
    pc1_n = ctl ? (bcpu ? bar : {a0[31:2], 2'b00}) : !c1_run ? pc1 :
            sc1 != 16'd0 ? (sc1 == 16'd1 ? pc1 + 32'd4 : pc1) : slp1 ? pc1 : npc(i1, pc1);
    sc1_n = ctl || !c1_run ? 16'd0 : sc1 != 16'd0 ? sc1 - 16'd1 : slp1 ? i1[15:0] : 16'd0;
    w1 = go1 ? dst(i1) : 5'd0;
    res1 = res(i1, a1, b1);
  end
  always_ff @(posedge sclk) begin
    if (reset && load) imem[addr[9:2]] <= instr;
  end
  always_ff @(posedge sclk) begin
    if (reset) begin
      pc0 <= '0;
      pc1 <= '0;
      bar <= '0;
      sc0 <= '0;
      sc1 <= '0;
      c1_run <= 1'b0;
      c1_bank <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r0[i] <= '0;
        r1[0][i] <= '0;
        r1[1][i] <= '0;
      end
    end else begin
      pc0 <= pc0_n;
      sc0 <= sc0_n;
      pc1 <= pc1_n;
      sc1 <= sc1_n;
      if (lba) bar <= {14'd0, i0[15:0], 2'b00};
      if (w0 != 5'd0) r0[w0] <= res0;
      if (ctl) r0[30] <= {pc1[31:2], 1'b0, c1_bank};
      if (w1 != 5'd0) r1[c1_bank][w1] <= res1;
      c1_run <= c1_run || ctl;
      c1_bank <= ctl ? (bcpu ? i0[16] : a0[0]) : c1_bank;
    end
  end
endmodule

// File: tb/tb_dual_core_ctx_cpu.sv
// tb_dual_core_ctx_cpu: scoreboard bench for dual_core_ctx_cpu driven by a directed two-core program
module tb_dual_core_ctx_cpu;
  logic sclk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] instr = '0;
  logic [31:0] pc0_o, pc1_o;
  logic c1_run_o, c1_bank_o;
  int checks = 0;
  int failures = 0;
  int ep = 0;
  int n = 0;
  logic pr = 1'b0;
  typedef struct {
    int ep;
    int n;
    int sel;
    int idx;
    logic [31:0] v;
    string nm;
  } exp_t;
  exp_t sb[$];
  dual_core_ctx_cpu dut (
    .sclk(sclk),
    .reset(reset),
    .load(load),
    .addr(addr),
    .instr(instr),
    .pc0_o(pc0_o),
    .pc1_o(pc1_o),
    .c1_run_o(c1_run_o),
    .c1_bank_o(c1_bank_o)
  );
  always #5 sclk = ~sclk;
  function automatic logic [31:0] rr(input int rs, rt, rd, f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(f)};
  endfunction
  function automatic logic [31:0] ii(input int op, rs, rt, imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] jj(input int t);
    return {6'h05, 26'(t)};
  endfunction
  function automatic logic [31:0] act(input int sel, idx);
    return sel == 0 ? pc0_o : sel == 1 ? pc1_o : sel == 2 ? {31'd0, c1_run_o} : sel == 3 ? {31'd0, c1_bank_o} :
           sel == 4 ? dut.r0[idx] : sel == 5 ? dut.r1[0][idx] : dut.r1[1][idx];
  endfunction
  task automatic ex(input int e, c, sel, idx, input logic [31:0] v, input string nm);
    exp_t x;
    x.ep = e;
    x.n = c;
    x.sel = sel;
    x.idx = idx;
    x.v = v;
    x.nm = nm;
    sb.push_back(x);
  endtask
  task automatic ld(input logic [31:0] a, w);
    load = 1'b1;
    addr = a;
    instr = w;
    @(posedge sclk);
    #1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge sclk);
      if (reset) begin
        if (!pr) ep++;
        n = 0;
      end else begin
        while (sb.size() > 0 && sb[0].ep == ep && sb[0].n == n) begin
          e = sb.pop_front();
          checks++;
          if (act(e.sel, e.idx) !== e.v) begin
            failures++;
            $display("FAIL %s ep=%0d n=%0d got=%h exp=%h", e.nm, ep, n, act(e.sel, e.idx), e.v);
          end
        end
        n++;
      end
      pr = reset;
    end
  end
  initial begin
    ex(1, 0, 0, 0, 32'h0, "rst_pc0");
    ex(1, 0, 1, 0, 32'h0, "rst_pc1");
    ex(1, 0, 2, 0, 32'h0, "rst_run");
    ex(1, 0, 3, 0, 32'h0, "rst_bank");
    ex(1, 1, 0, 0, 32'h4, "nop_pc0_4");
    ex(1, 2, 0, 0, 32'h8, "nop_pc0_8");
    ex(1, 3, 0, 0, 32'hC, "nop_pc0_c");
    ex(1, 3, 2, 0, 32'h0, "idle_run");
    ex(1, 4, 0, 0, 32'h10, "sleep_pc0_a");
    ex(1, 7, 0, 0, 32'h10, "sleep_pc0_b");
    ex(1, 8, 0, 0, 32'h14, "sleep_done");
    ex(1, 9, 4, 2, 32'h5, "addi_r2");
    ex(1, 10, 4, 3, 32'hA, "add_r3");
    ex(1, 14, 4, 4, 32'hFFFF_FFFF, "addi_neg_r4");
    ex(1, 14, 4, 5, 32'hFFFF_FFFA, "sub_r5");
    ex(1, 14, 4, 6, 32'hA, "and_r6");
    ex(1, 14, 4, 7, 32'hF, "or_r7");
    ex(1, 15, 1, 0, 32'h0, "pre_bcpu_pc1");
    ex(1, 15, 2, 0, 32'h0, "pre_bcpu_run");
    ex(1, 16, 0, 0, 32'h34, "bcpu_pc0");
    ex(1, 16, 1, 0, 32'h50, "bcpu_pc1");
    ex(1, 16, 2, 0, 32'h1, "bcpu_run");
    ex(1, 16, 3, 0, 32'h0, "bcpu_bank");
    ex(1, 16, 4, 30, 32'h0, "bcpu_r30");
    ex(1, 22, 1, 0, 32'h5C, "c1_j_land");
    ex(1, 24, 1, 0, 32'h64, "c1_loop_end");
    ex(1, 24, 5, 2, 32'h2, "b0_cnt_2");
    ex(1, 27, 5, 2, 32'h3, "b0_cnt_3");
    ex(1, 36, 0, 0, 32'h34, "sleep20_hold");
    ex(1, 37, 0, 0, 32'h38, "sleep20_done");
    ex(1, 38, 1, 0, 32'h60, "pre_sw_pc1");
    ex(1, 38, 5, 2, 32'h6, "pre_sw_b0");
    ex(1, 39, 1, 0, 32'h6C, "sw_pc1");
    ex(1, 39, 3, 0, 32'h1, "sw_bank");
    ex(1, 39, 4, 30, 32'h60, "sw_r30");
    ex(1, 50, 1, 0, 32'h70, "b1_pc1");
    ex(1, 50, 6, 2, 32'hC, "b1_cnt");
    ex(1, 50, 5, 2, 32'h6, "b0_frozen");
    ex(1, 61, 4, 2, 32'h60, "move_r2");
    ex(1, 62, 0, 0, 32'h4C, "jr_pc0");
    ex(1, 62, 1, 0, 32'h60, "jr_pc1");
    ex(1, 62, 3, 0, 32'h0, "jr_bank");
    ex(1, 62, 4, 30, 32'h6D, "jr_r30");
    ex(1, 62, 6, 2, 32'h16, "b1_frozen");
    ex(1, 63, 1, 0, 32'h64, "resume_pc1");
    ex(1, 63, 5, 2, 32'h7, "resume_b0");
    ex(1, 66, 5, 2, 32'h8, "resume_b0_8");
    ex(1, 66, 0, 0, 32'h4C, "load_ignored");
    ex(2, 0, 0, 0, 32'h0, "rr_pc0");
    ex(2, 0, 1, 0, 32'h0, "rr_pc1");
    ex(2, 0, 2, 0, 32'h0, "rr_run");
    ex(2, 0, 3, 0, 32'h0, "rr_bank");
    ex(2, 0, 4, 3, 32'h0, "rr_r3");
    ex(2, 0, 4, 30, 32'h0, "rr_r30");
    ex(2, 0, 5, 2, 32'h0, "rr_b0");
    ex(2, 0, 6, 2, 32'h0, "rr_b1");
    ex(2, 8, 0, 0, 32'h14, "rr_sleep");
    ex(2, 10, 4, 3, 32'hA, "rr_add_r3");
    ex(2, 16, 1, 0, 32'h50, "rr_bcpu_pc1");
    ex(2, 16, 2, 0, 32'h1, "rr_bcpu_run");
    for (int i = 0; i < 4; i++) ld(32'(4 * i), rr(0, 0, 0, 8));
    ld(32'h10, ii(8, 0, 0, 3));
    ld(32'h14, ii(8'h28, 0, 2, 5));
    ld(32'h18, rr(2, 2, 3, 8));
    ld(32'h1C, ii(8'h28, 0, 4, -1));
    ld(32'h20, rr(4, 2, 5, 8'h0A));
    ld(32'h24, rr(4, 3, 6, 8'h0C));
    ld(32'h28, rr(2, 3, 7, 8'h0D));
    ld(32'h2C, ii(8'h0D, 0, 0, 8'h14));
    ld(32'h30, ii(8'h0C, 1, 0, 0));
    ld(32'h34, ii(8, 0, 0, 20));
    ld(32'h38, ii(8'h0D, 0, 0, 8'h1B));
    ld(32'h3C, ii(8'h0C, 1, 1, 0));
    ld(32'h40, ii(8, 0, 0, 20));
    ld(32'h44, rr(30, 0, 2, 8));
    ld(32'h48, ii(8'h0F, 2, 0, 0));
    ld(32'h4C, jj(8'h13));
    ld(32'h50, rr(0, 0, 0, 8));
    ld(32'h54, rr(0, 0, 0, 8));
    ld(32'h58, ii(8'h28, 0, 2, 0));
    ld(32'h5C, rr(0, 0, 0, 8));
    ld(32'h60, ii(8'h28, 2, 2, 1));
    ld(32'h64, jj(8'h17));
    ld(32'h6C, ii(8'h28, 2, 2, 2));
    ld(32'h70, jj(8'h1B));
    load = 1'b0;
    @(posedge sclk);
    #1 reset = 1'b0;
    repeat (62) @(posedge sclk);
    #1;
    load = 1'b1;
    addr = 32'h4C;
    instr = 32'h0000_0008;
    repeat (3) @(posedge sclk);
    #1 load = 1'b0;
    repeat (5) @(posedge sclk);
    #1 reset = 1'b1;
    @(posedge sclk);
    #1 reset = 1'b0;
    repeat (20) @(posedge sclk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      checks += sb.size();
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
